// File: rtl/ctrl_pkg.sv
// Shared control-word types for the issue sequencer and Reg_Control.
// One packed word carries every decoded execute-stage control field.
package ctrl_pkg;

  typedef struct packed {
    logic       alu_st;
    logic       mem_st;
    logic       shift_op;
    logic [1:0] mem_op;
    logic [1:0] esc_wr;
    logic [1:0] vec_wr;
    logic [3:0] alu_op;
  } ctrl_word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SINGLE,
    S_BURST
  } state_t;

  localparam ctrl_word_t CTRL_NOP = '0;

endpackage

// File: rtl/ctrl_issue_seq.sv
// Issue sequencer feeding Reg_Control: forwards single-beat ops and
// expands vector memory ops into NUM_BEATS beats under stall/flush.
module ctrl_issue_seq
  import ctrl_pkg::*;
#(
  parameter int NUM_BEATS = 4,
  parameter int BEAT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_vec_mem,
  input  logic              in_cl_alu_st,
  input  logic              in_cl_mem_st,
  input  logic              in_cl_shift_op,
  input  logic [1:0]        in_cl_mem_op,
  input  logic [1:0]        in_cl_esc_wr,
  input  logic [1:0]        in_cl_vec_wr,
  input  logic [3:0]        in_cl_alu_op,
  input  logic              stall,
  input  logic              flush,
  output logic              out_en,
  output logic              out_cl_alu_st,
  output logic              out_cl_mem_st,
  output logic              out_cl_shift_op,
  output logic [1:0]        out_cl_mem_op,
  output logic [1:0]        out_cl_esc_wr,
  output logic [1:0]        out_cl_vec_wr,
  output logic [3:0]        out_cl_alu_op,
  output logic [BEAT_W-1:0] out_beat,
  output logic              out_last,
  output logic              busy
);

  localparam logic [BEAT_W-1:0] LAST_BEAT =
    BEAT_W'(NUM_BEATS - 1);
  localparam bit MULTI = (NUM_BEATS > 1);

  state_t              state;
  ctrl_word_t          word_q;
  ctrl_word_t          word_d;
  logic [BEAT_W-1:0]   beat_q;
  logic                consume;
  logic                accept;
  logic                idle;

  assign idle     = (state == S_IDLE);
  assign consume  = ~idle & ~stall & ~flush;
  assign out_last = (state == S_SINGLE) |
                    ((state == S_BURST) &
                     (beat_q == LAST_BEAT));
  assign in_ready = ~reset & ~flush &
                    (idle | (consume & out_last));
  assign accept   = in_valid & in_ready;
  assign out_en   = consume;
  assign busy     = ~idle;
  assign out_beat = beat_q;

  assign word_d = '{
    alu_st:   in_cl_alu_st,
    mem_st:   in_cl_mem_st,
    shift_op: in_cl_shift_op,
    mem_op:   in_cl_mem_op,
    esc_wr:   in_cl_esc_wr,
    vec_wr:   in_cl_vec_wr,
    alu_op:   in_cl_alu_op
  };

  assign out_cl_alu_st   = word_q.alu_st;
  assign out_cl_mem_st   = word_q.mem_st;
  assign out_cl_shift_op = word_q.shift_op;
  assign out_cl_mem_op   = word_q.mem_op;
  assign out_cl_esc_wr   = word_q.esc_wr;
  assign out_cl_vec_wr   = word_q.vec_wr;
  assign out_cl_alu_op   = word_q.alu_op;

  // Accept has priority over retire so the last beat and the
  // next word hand over without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      word_q <= CTRL_NOP;
      beat_q <= '0;
    end else if (flush) begin
      state  <= S_IDLE;
      word_q <= CTRL_NOP;
      beat_q <= '0;
    end else if (accept) begin
      word_q <= word_d;
      beat_q <= '0;
      state  <= (in_vec_mem && MULTI) ? S_BURST : S_SINGLE;
    end else if (consume) begin
      if (!out_last) begin
        beat_q <= beat_q + BEAT_W'(1);
      end else begin
        state <= S_IDLE;
      end
    end
  end

endmodule

// File: doc/ctrl_issue_seq.md
Name: ctrl_issue_seq

Overview:
Issue sequencer directly upstream of the execute-stage control register (Reg_Control).
- Accepts one decoded control word per instruction from the decoder over a valid/ready handshake.
- Single-beat ops are forwarded once.
- Vector memory ops are expanded into NUM_BEATS element-group beats.
- Drives the register's enable so the register captures each beat exactly once, honouring downstream stall and pipeline flush.

Parameters:
- NUM_BEATS, 4: beats per vector memory instruction; legal range is 1 or more.
- BEAT_W, max(1,$clog2(NUM_BEATS)): width of the beat index.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decoder presents a control word
- in_ready  out  1  sequencer accepts the word this cycle
- in_vec_mem  in  1  instruction is a vector memory access (multi-beat)
- in_cl_alu_st  in  1  decoded ALU-store control
- in_cl_mem_st  in  1  decoded memory-store control
- in_cl_shift_op  in  1  decoded shift select
- in_cl_mem_op  in  2  decoded memory op
- in_cl_esc_wr  in  2  decoded scalar write-back select
- in_cl_vec_wr  in  2  decoded vector write-back select
- in_cl_alu_op  in  4  decoded ALU op
- stall  in  1  downstream cannot take a beat this cycle
- flush  in  1  discard the in-flight instruction
- out_en  out  1  enable to Reg_Control; the beat is consumed when this is high
- out_cl_alu_st, out_cl_mem_st, out_cl_shift_op  out  1 each  held control fields
- out_cl_mem_op, out_cl_esc_wr, out_cl_vec_wr  out  2 each  held control fields
- out_cl_alu_op  out  4  held control field
- out_beat  out  BEAT_W  current beat index
- out_last  out  1  current beat is the final beat of the instruction
- busy  out  1  an instruction is held (state is not S_IDLE)

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high.
- FSM states: S_IDLE, S_SINGLE, S_BURST.
- Registers: word_q (all cl fields), beat_q, state.
- Reset: state=S_IDLE, word_q=0, beat_q=0. While reset is high, in_ready=0 and out_en=0. All out_* read 0 after reset.
- Combinational outputs:
  - consume = (state!=S_IDLE) & ~stall & ~flush
  - out_en = consume
  - out_last = (state==S_SINGLE) | (state==S_BURST & beat_q==NUM_BEATS-1)
  - in_ready = ~reset & ~flush & (state==S_IDLE | (consume & out_last))
  - busy = (state!=S_IDLE)
- Accept (in_valid & in_ready):
  - word_q <= in fields; beat_q <= 0.
  - state <= S_BURST if (in_vec_mem & NUM_BEATS>1), else S_SINGLE.
  - Latency: word accepted in cycle t is presented with out_en=1 in cycle t+1 if stall is low.
- Transitions:
  - consume & ~out_last: beat_q <= beat_q+1; stay in S_BURST.
  - consume & out_last & no accept: state <= S_IDLE.
  - consume & out_last & accept (simultaneous): load the next word. This gives back-to-back issue with no bubble.
- Stall: out_en=0; word_q, beat_q and state hold; in_ready=0 unless already S_IDLE.
- Flush:
  - Highest priority after reset, over stall and accept.
  - out_en=0 and in_ready=0 in the flush cycle.
  - Next cycle: state=S_IDLE, word_q=0, beat_q=0.
  - Remaining beats are dropped.
- out_cl_* = word_q at all times. Outputs are stable for the whole time a beat waits under stall.
- Beat index never wraps past NUM_BEATS-1. NUM_BEATS=1 makes every op single-beat.
- Throughput: 1 instruction/cycle for single-beat ops; NUM_BEATS cycles for vector memory ops, stall-free.

Decomposition:
- Shared package ctrl_pkg holds:
  - typedef ctrl_word_t, a packed struct of the seven cl fields (alu_st, mem_st, shift_op, mem_op[1:0], esc_wr[1:0], vec_wr[1:0], alu_op[3:0]).
  - the state enum.
  - constant CTRL_NOP = '0.
- Reg_Control and ctrl_issue_seq both use ctrl_word_t.
- No sub-module. A single always_ff block plus combinational next-state logic is sufficient.

Test Plan:
1. Reset high 2 cycles, then low -> in_ready=1, out_en=0, busy=0, all out_cl_*=0.
2. Single op alu_op=4'd3, mem_op=2'd2, esc_wr=2'd2, vec_wr=2'd1, in_vec_mem=0 -> next cycle out_en=1, out_last=1, out_beat=0, fields match; the cycle after, busy=0.
3. Vector op in_vec_mem=1, NUM_BEATS=4, stall=0 -> out_en=1 for 4 consecutive cycles, out_beat=0,1,2,3, out_last only on beat 3; in_ready=0 until beat 3.
4. Stall during burst: stall=1 for 2 cycles at beat 1 -> out_en=0, out_beat holds 1, fields unchanged; then beats 1,2,3 complete.
5. Back-to-back: a second single op is offered during beat 3 of a burst -> accepted that cycle; its word is presented next cycle with out_en=1 and no bubble.
6. Flush at beat 2 of a burst -> out_en=0 that cycle; next cycle busy=0, out_cl_*=0, in_ready=1; flush together with stall still clears the instruction.
